// File: rtl/ring_osc_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package ring_osc_pkg;

    localparam int unsigned MAX_OSC           = 8;
    localparam int unsigned DEF_NUM_OSC       = 4;
    localparam int unsigned DEF_SEL_W         = 3;
    localparam int unsigned DEF_GATE_W        = 16;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } meas_state_t;

    // Indices at or beyond MAX_OSC decode to all zeros.
    function automatic logic [MAX_OSC-1:0] onehot_en(input int unsigned idx);
        logic [MAX_OSC-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_OSC; i++) begin
            if (i == idx) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Single-bit 2-flop synchronizer followed by a rising-edge detector.
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [2:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[1:0], i_async};
    end

    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, settle, gated edge count, report.
// Define RING_MEAS_WRAP_EN to make the edge counter wrap instead of saturating.
module ring_osc_meas_ctrl
    import ring_osc_pkg::*;
#(
    parameter int unsigned NUM_OSC       = DEF_NUM_OSC,
    parameter int unsigned SEL_W         = DEF_SEL_W,
    parameter int unsigned GATE_W        = DEF_GATE_W,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [SEL_W-1:0]   i_osc_sel,
    input  logic [GATE_W-1:0]  i_gate_cycles,
    input  logic [NUM_OSC-1:0] i_osc_in,
    output logic [NUM_OSC-1:0] o_osc_en,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_overflow,
    output logic               o_sel_err
);

    localparam int unsigned    SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    meas_state_t        r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [GATE_W-1:0]  r_gate;
    logic [SET_W-1:0]   r_settle;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_sel_err;

    logic [NUM_OSC-1:0] w_rise;
    logic [NUM_OSC-1:0] w_sel_mask;
    logic               w_start_valid;
    logic               w_edge;
    logic [CNT_W-1:0]   w_count_inc;

    for (genvar g = 0; g < NUM_OSC; g++) begin : g_sync
        osc_edge_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (i_osc_in[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_start_valid = (32'(i_osc_sel) < NUM_OSC);
    assign w_sel_mask    = NUM_OSC'(onehot_en(32'(r_sel)));
    assign w_edge        = |(w_rise & w_sel_mask);
    assign w_count_inc   = r_count + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = w_start_valid ? SETTLE : DONE;
            SETTLE:  if (r_settle == '0) w_state_nxt = (r_gate == '0) ? DONE : MEASURE;
            MEASURE: if (r_gate == GATE_W'(1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_gate is reused as the down-counting gate timer once MEASURE starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_gate     <= '0;
            r_settle   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sel      <= i_osc_sel;
                        r_gate     <= i_gate_cycles;
                        r_settle   <= SETTLE_LAST;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_sel_err  <= ~w_start_valid;
                    end
                end
                SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
                end
                MEASURE: begin
                    r_gate <= r_gate - GATE_W'(1);
                    if (w_edge) begin
`ifdef RING_MEAS_WRAP_EN
                        r_count <= w_count_inc;
                        if (r_count == '1) r_overflow <= 1'b1;
`else
                        if (r_count != '1) begin
                            r_count <= w_count_inc;
                            if (w_count_inc == '1) r_overflow <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_osc_en   = (r_state == SETTLE || r_state == MEASURE) ? w_sel_mask : '0;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_sel_err  = r_sel_err;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Scoreboard bench for ring_osc_meas_ctrl (CNT_W=4 so saturation/wrap is reachable).
module tb_ring_osc_meas_ctrl;

    localparam int unsigned NUM_OSC = 4;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned GATE_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SETTLE  = 16;
`ifdef RING_MEAS_WRAP_EN
    localparam int unsigned OVF_CNT = 2;   // 50 edges mod 16
`else
    localparam int unsigned OVF_CNT = 15;  // saturated
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [SEL_W-1:0]   osc_sel = '0;
    logic [GATE_W-1:0]  gate = '0;
    logic [NUM_OSC-1:0] osc_in = '0;
    logic [NUM_OSC-1:0] osc_en;
    logic               busy, done, overflow, sel_err;
    logic [CNT_W-1:0]   count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned per_bad = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int unsigned        a;     // cycle index of the accepting edge
        int unsigned        dur;   // cycles from accept to DONE
        logic [NUM_OSC-1:0] mask;
        logic [CNT_W-1:0]   cnt;
        logic               ovf;
        logic               serr;
    } exp_t;

    exp_t sbq[$];

    ring_osc_meas_ctrl #(
        .NUM_OSC       (NUM_OSC),
        .SEL_W         (SEL_W),
        .GATE_W        (GATE_W),
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_osc_sel     (osc_sel),
        .i_gate_cycles (gate),
        .i_osc_in      (osc_in),
        .o_osc_en      (osc_en),
        .o_busy        (busy),
        .o_done        (done),
        .o_count       (count),
        .o_overflow    (overflow),
        .o_sel_err     (sel_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Rising edges seen at posedge j where j%4==0 (bit0), (j+1)%4==0 (bit3), j%8==0 (bit2).
    initial forever begin
        @(negedge clk);
        osc_in[0] = ((cyc + 1) % 4) < 2;
        osc_in[1] = 1'b0;
        osc_in[2] = ((cyc + 1) % 8) < 4;
        osc_in[3] = ((cyc + 2) % 4) < 2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin
        exp_t               e;
        logic [NUM_OSC-1:0] en_exp;
        logic               busy_exp;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                en_exp   = '0;
                busy_exp = 1'b0;
                if (sbq.size() > 0) begin
                    if (cyc >= sbq[0].a && cyc <= sbq[0].a + sbq[0].dur) busy_exp = 1'b1;
                    if (cyc >= sbq[0].a && cyc < sbq[0].a + sbq[0].dur) en_exp = sbq[0].mask;
                end
                if (osc_en !== en_exp || busy !== busy_exp) per_bad++;
            end
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("count",    32'(count),        32'(e.cnt));
                    chk("overflow", 32'(overflow),     32'(e.ovf));
                    chk("sel_err",  32'(sel_err),      32'(e.serr));
                    chk("latency",  cyc - e.a + 1,     e.dur + 1);
                    chk("busy_done", 32'(busy),        32'd1);
                    chk("en_busy_cycles_bad", per_bad, 32'd0);
                    per_bad = 0;
                end
            end
        end
    end

    // Called at a negedge; the accepting edge is the next posedge.
    task automatic issue(input int unsigned sel, input int unsigned g,
                         input int unsigned cnt, input bit ovf);
        exp_t e;
        osc_sel = SEL_W'(sel);
        gate    = GATE_W'(g);
        start   = 1'b1;
        e.a     = cyc + 1;
        e.serr  = (sel >= NUM_OSC);
        e.dur   = e.serr ? 0 : SETTLE + g;
        e.mask  = '0;
        if (!e.serr) e.mask[sel] = 1'b1;
        e.cnt   = CNT_W'(cnt);
        e.ovf   = ovf;
        sbq.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        osc_sel = '0;
        gate    = '1;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", sbq.size(), budget);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_osc_en"},   32'(osc_en),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_count"},    32'(count),    32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_sel_err"},  32'(sel_err),  32'd0);
    endtask

    initial begin
        int unsigned a0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-MEASURE: enable must drop asynchronously, no done.
        osc_sel = 3'd1;
        gate    = 16'd100;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (25) @(negedge clk);
        chk("en_before_rst", 32'(osc_en), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("en_async_rst", 32'(osc_en), 32'd0);
        chk("done_async_rst", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_rst");
        mon_en = 1'b1;

        issue(2, 64, 8, 1'b0);           // basic, period 8
        wait_done(200);
        issue(1, 100, 0, 1'b0);          // selectivity: only quiet bit selected
        wait_done(300);
        issue(2, 0, 0, 1'b0);            // zero gate
        wait_done(100);
        issue(5, 64, 0, 1'b0);           // out-of-range select
        wait_done(20);
        issue(0, 200, OVF_CNT, 1'b1);    // 50 edges into a 4-bit counter
        wait_done(400);
        issue(3, 200, OVF_CNT, 1'b1);
        wait_done(400);
        repeat (5) @(negedge clk);
        chk("count_held",    32'(count),    32'(OVF_CNT));
        chk("overflow_held", 32'(overflow), 32'd1);

        // Handshake: starts during MEASURE and DONE ignored, start right after DONE accepted.
        issue(2, 32, 4, 1'b0);
        a0 = cyc;
        while (cyc < a0 + 20) @(negedge clk);
        osc_sel = 3'd5;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        while (cyc < a0 + SETTLE + 32) @(negedge clk);
        chk("done_cycle_seen", 32'(done), 32'd1);
        osc_sel = 3'd5;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        issue(1, 8, 0, 1'b0);
        wait_done(200);
        repeat (10) @(negedge clk);
        chk("idle_tail_bad", per_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
